fault_target_array: RTL and testbench

//  Parametrised array of laser-fault target registers with on-chip flip detection.

---
 rtl/fault_target_array_pkg.sv | 14 +
 rtl/fault_target_array_lsb_index.sv | 24 ++
 rtl/fault_target_array.sv | 171 +++++++++++++++++
 tb/tb_fault_target_array.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_target_array_pkg.sv
// Shared types for the laser-fault target array: FSM state encoding.
package fault_target_array_pkg;

    // Encodings are visible on the state pins, so the values are fixed.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StArmed   = 2'd2,
        StTripped = 2'd3
    } state_e;

    localparam int unsigned StateW = 2;

endpackage

// File: rtl/fault_target_array_lsb_index.sv
// Combinational lowest-set-bit encoder with a valid flag.
module fault_target_array_lsb_index #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int unsigned IdxW = $clog2(N);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IdxW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fault_target_array.sv
// Array of fault-target flops compared every cycle against a golden copy.
// Records sticky per-bit flags, a saturating count and the first fault index/time.
module fault_target_array
    import fault_target_array_pkg::*;
#(
    parameter int unsigned N_REGS        = 8,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned TIME_W        = 16,
    parameter bit          STOP_ON_FAULT = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [N_REGS-1:0]         pattern,
    input  logic                      arm,
    input  logic                      disarm,
    input  logic [N_REGS-1:0]         en_mask,
    input  logic [N_REGS-1:0]         inj,
    output logic [N_REGS-1:0]         targets,
    output logic [N_REGS-1:0]         fault_flags,
    output logic [CNT_W-1:0]          fault_count,
    output logic [$clog2(N_REGS)-1:0] first_idx,
    output logic [TIME_W-1:0]         first_time,
    output logic                      fault,
    output logic [StateW-1:0]         state
);

    localparam int unsigned IdxW = $clog2(N_REGS);
    localparam logic [CNT_W-1:0]  CntMax  = '1;
    localparam logic [TIME_W-1:0] TimeMax = '1;

    function automatic int unsigned popcount(input logic [N_REGS-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < N_REGS; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

    state_e state_q, state_d;

    // Kept so synthesis never merges or prunes the physical fault targets.
    (* keep = "true", dont_touch = "true" *) logic [N_REGS-1:0] targets_q;
    logic [N_REGS-1:0] golden_q;
    logic [N_REGS-1:0] flags_q;
    logic [CNT_W-1:0]  count_q;
    logic [IdxW-1:0]   first_idx_q;
    logic [TIME_W-1:0] first_time_q;
    logic [TIME_W-1:0] timer_q;
    logic              fault_q;

    logic [N_REGS-1:0] mism;
    logic [N_REGS-1:0] new_bits;
    logic [IdxW-1:0]   new_idx;
    logic              new_valid;
    logic [31:0]       count_sum;
    logic [CNT_W-1:0]  count_next;
    logic [TIME_W-1:0] timer_next;

    // Mismatch is taken from the registered targets, so an injected flip shows a cycle later.
    always_comb begin
        mism       = (targets_q ^ golden_q) & en_mask;
        new_bits   = mism & ~flags_q;
        count_sum  = 32'(count_q) + popcount(new_bits);
        count_next = (count_sum > 32'(CntMax)) ? CntMax : CNT_W'(count_sum);
        timer_next = (timer_q == TimeMax) ? timer_q : timer_q + TIME_W'(1);
    end

    fault_target_array_lsb_index #(
        .N (N_REGS)
    ) u_lsb_index (
        .vec   (new_bits),
        .idx   (new_idx),
        .valid (new_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: load beats arm in IDLE; disarm beats tripping in ARMED.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StLoad;
                end else if (arm) begin
                    state_d = StArmed;
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            StArmed: begin
                if (disarm) begin
                    state_d = StIdle;
                end else if (STOP_ON_FAULT && new_valid) begin
                    state_d = StTripped;
                end
            end
            StTripped: begin
                if (disarm) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: targets, golden copy, sticky flags, counters and first-fault capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            targets_q    <= '0;
            golden_q     <= '0;
            flags_q      <= '0;
            count_q      <= '0;
            first_idx_q  <= '0;
            first_time_q <= '0;
            timer_q      <= '0;
            fault_q      <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!load && arm) begin
                        timer_q <= '0;
                    end
                end
                StLoad: begin
                    targets_q    <= pattern;
                    golden_q     <= pattern;
                    flags_q      <= '0;
                    count_q      <= '0;
                    first_idx_q  <= '0;
                    first_time_q <= '0;
                    timer_q      <= '0;
                end
                StArmed: begin
                    targets_q <= targets_q ^ inj;
                    timer_q   <= timer_next;
                    if (new_valid) begin
                        flags_q <= flags_q | new_bits;
                        count_q <= count_next;
                        fault_q <= 1'b1;
                        if (flags_q == '0) begin
                            first_idx_q  <= new_idx;
                            first_time_q <= timer_q;
                        end
                    end
                end
                default: ; // TRIPPED: everything frozen for readback
            endcase
        end
    end

    assign targets     = targets_q;
    assign fault_flags = flags_q;
    assign fault_count = count_q;
    assign first_idx   = first_idx_q;
    assign first_time  = first_time_q;
    assign fault       = fault_q;
    assign state       = state_q;

endmodule

// File: tb/tb_fault_target_array.sv
// Bench: three configurations driven in lockstep and checked against a cycle model.
//   0: STOP_ON_FAULT=1  1: STOP_ON_FAULT=0  2: STOP_ON_FAULT=0, CNT_W=2, TIME_W=4
module tb_fault_target_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, load, arm, disarm;
    logic [7:0] pattern, en_mask, inj;

    logic [7:0]  tgt0, tgt1, tgt2, flg0, flg1, flg2;
    logic [7:0]  cnt0, cnt1;
    logic [1:0]  cnt2;
    logic [2:0]  idx0, idx1, idx2;
    logic [15:0] ft0, ft1;
    logic [3:0]  ft2;
    logic        flt0, flt1, flt2;
    logic [1:0]  st0, st1, st2;

    fault_target_array #(.N_REGS(8), .CNT_W(8), .TIME_W(16), .STOP_ON_FAULT(1'b1)) u0 (
        .clk(clk), .rst(rst), .load(load), .pattern(pattern), .arm(arm), .disarm(disarm),
        .en_mask(en_mask), .inj(inj), .targets(tgt0), .fault_flags(flg0), .fault_count(cnt0),
        .first_idx(idx0), .first_time(ft0), .fault(flt0), .state(st0));
    fault_target_array #(.N_REGS(8), .CNT_W(8), .TIME_W(16), .STOP_ON_FAULT(1'b0)) u1 (
        .clk(clk), .rst(rst), .load(load), .pattern(pattern), .arm(arm), .disarm(disarm),
        .en_mask(en_mask), .inj(inj), .targets(tgt1), .fault_flags(flg1), .fault_count(cnt1),
        .first_idx(idx1), .first_time(ft1), .fault(flt1), .state(st1));
    fault_target_array #(.N_REGS(8), .CNT_W(2), .TIME_W(4), .STOP_ON_FAULT(1'b0)) u2 (
        .clk(clk), .rst(rst), .load(load), .pattern(pattern), .arm(arm), .disarm(disarm),
        .en_mask(en_mask), .inj(inj), .targets(tgt2), .fault_flags(flg2), .fault_count(cnt2),
        .first_idx(idx2), .first_time(ft2), .fault(flt2), .state(st2));

    logic [31:0] o_tgt[3], o_flg[3], o_cnt[3], o_idx[3], o_ft[3], o_flt[3], o_st[3];
    assign o_tgt[0] = 32'(tgt0);  assign o_tgt[1] = 32'(tgt1);  assign o_tgt[2] = 32'(tgt2);
    assign o_flg[0] = 32'(flg0);  assign o_flg[1] = 32'(flg1);  assign o_flg[2] = 32'(flg2);
    assign o_cnt[0] = 32'(cnt0);  assign o_cnt[1] = 32'(cnt1);  assign o_cnt[2] = 32'(cnt2);
    assign o_idx[0] = 32'(idx0);  assign o_idx[1] = 32'(idx1);  assign o_idx[2] = 32'(idx2);
    assign o_ft[0]  = 32'(ft0);   assign o_ft[1]  = 32'(ft1);   assign o_ft[2]  = 32'(ft2);
    assign o_flt[0] = 32'(flt0);  assign o_flt[1] = 32'(flt1);  assign o_flt[2] = 32'(flt2);
    assign o_st[0]  = 32'(st0);   assign o_st[1]  = 32'(st1);   assign o_st[2]  = 32'(st2);

    // Reference model: state 0=IDLE 1=LOAD 2=ARMED 3=TRIPPED, plain integers.
    int unsigned p_stop[3] = '{1, 0, 0};
    int unsigned p_cmax[3] = '{255, 255, 3};
    int unsigned p_tmax[3] = '{65535, 65535, 15};
    int unsigned m_st[3], m_tgt[3], m_gold[3], m_flg[3], m_cnt[3], m_idx[3], m_ft[3], m_tmr[3];
    int unsigned m_flt[3];

    int n_vec = 0;
    int n_err = 0;

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int unsigned nb, nst, sum;
            nst = m_st[k];
            m_flt[k] = 0;
            if (rst) begin
                m_st[k] = 0; m_tgt[k] = 0; m_gold[k] = 0; m_flg[k] = 0;
                m_cnt[k] = 0; m_idx[k] = 0; m_ft[k] = 0; m_tmr[k] = 0;
                nst = 0;
            end else begin
                case (m_st[k])
                    0: begin
                        if (load) nst = 1;
                        else if (arm) begin nst = 2; m_tmr[k] = 0; end
                    end
                    1: begin
                        m_tgt[k] = pattern; m_gold[k] = pattern;
                        m_flg[k] = 0; m_cnt[k] = 0; m_idx[k] = 0; m_ft[k] = 0; m_tmr[k] = 0;
                        nst = 0;
                    end
                    2: begin
                        nb = (m_tgt[k] ^ m_gold[k]) & 32'(en_mask) & ~m_flg[k] & 32'hFF;
                        if (nb != 0) begin
                            if (m_flg[k] == 0) begin
                                for (int b = 7; b >= 0; b--) if (nb[b]) m_idx[k] = b;
                                m_ft[k] = m_tmr[k];
                            end
                            m_flg[k] = m_flg[k] | nb;
                            sum = m_cnt[k] + $countones(nb);
                            m_cnt[k] = (sum > p_cmax[k]) ? p_cmax[k] : sum;
                            m_flt[k] = 1;
                        end
                        m_tgt[k] = (m_tgt[k] ^ 32'(inj)) & 32'hFF;
                        m_tmr[k] = (m_tmr[k] < p_tmax[k]) ? m_tmr[k] + 1 : p_tmax[k];
                        if (disarm) nst = 0;
                        else if (p_stop[k] == 1 && nb != 0) nst = 3;
                    end
                    default: if (disarm) nst = 0;
                endcase
                m_st[k] = nst;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic go_idle();
        disarm = 1'b1; step(); disarm = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] p);
        pattern = p; load = 1'b1; step(); load = 1'b0; step();
    endtask

    task automatic do_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (o_st[k] !== 0 || o_tgt[k] !== 0 || o_flg[k] !== 0 || o_cnt[k] !== 0 ||
                o_idx[k] !== 0 || o_ft[k] !== 0 || o_flt[k] !== 0) begin
                n_err++;
                $display("FAIL reset[%0d]: got st=%0d tgt=%h flg=%h cnt=%0d idx=%0d ft=%0d flt=%0d want all 0",
                         k, o_st[k], o_tgt[k], o_flg[k], o_cnt[k], o_idx[k], o_ft[k], o_flt[k]);
            end
        end
    endtask

    task automatic test_detect_stop();
        en_mask = 8'hFF;
        do_load(8'hA5);
        do_arm();
        for (int i = 0; i < 10 && m_tmr[0] != 4; i++) step();
        inj = 8'h10; step(); inj = 8'h00;
        n_vec++;
        if (flt0 !== 1'b0) begin n_err++; $display("FAIL detect_early_fault: got %b want 0", flt0); end
        step();
        n_vec++;
        if (tgt0 !== 8'hB5 || flg0 !== 8'h10 || cnt0 !== 8'd1 || idx0 !== 3'd4 || ft0 !== 16'd5 ||
            flt0 !== 1'b1 || st0 !== 2'd3) begin
            n_err++;
            $display("FAIL detect_stop: got tgt=%h flg=%h cnt=%0d idx=%0d ft=%0d flt=%b st=%0d want b5 10 1 4 5 1 3",
                     tgt0, flg0, cnt0, idx0, ft0, flt0, st0);
        end
        inj = 8'h01; step(); inj = 8'h00;
        n_vec++;
        if (flt0 !== 1'b0 || tgt0 !== 8'hB5 || st0 !== 2'd3) begin
            n_err++;
            $display("FAIL tripped_hold: got flt=%b tgt=%h st=%0d want 0 b5 3", flt0, tgt0, st0);
        end
        for (int k = 1; k < 3; k++) begin
            n_vec++;
            if (o_st[k] !== 2 || o_flg[k] !== m_flg[k]) begin
                n_err++;
                $display("FAIL detect_nostop[%0d]: got st=%0d flg=%h want 2 %h", k, o_st[k], o_flg[k], m_flg[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; step(); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (o_st[k] !== 0 || o_tgt[k] !== 0 || o_flg[k] !== 0 || o_cnt[k] !== 0 ||
                o_idx[k] !== 0 || o_ft[k] !== 0 || o_flt[k] !== 0) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got st=%0d tgt=%h flg=%h cnt=%0d want all 0",
                         k, o_st[k], o_tgt[k], o_flg[k], o_cnt[k]);
            end
        end
    endtask

    task automatic test_accumulate();
        go_idle(); do_load(8'h00); do_arm();
        inj = 8'h03; step();
        inj = 8'h01; step();
        n_vec++;
        if (flt1 !== 1'b1) begin n_err++; $display("FAIL accum_fault1: got %b want 1", flt1); end
        inj = 8'h00; step();
        n_vec++;
        if (flt1 !== 1'b0 || flg1 !== 8'h03 || cnt1 !== 8'd2 || st1 !== 2'd2 || tgt1 !== 8'h02) begin
            n_err++;
            $display("FAIL accum: got flt=%b flg=%h cnt=%0d st=%0d tgt=%h want 0 03 2 2 02",
                     flt1, flg1, cnt1, st1, tgt1);
        end
        n_vec++;
        if (st0 !== 2'd3 || flg0 !== 8'h03) begin
            n_err++; $display("FAIL accum_stop: got st=%0d flg=%h want 3 03", st0, flg0);
        end
    endtask

    task automatic test_mask();
        go_idle(); do_load(8'h00); en_mask = 8'hFE; do_arm();
        inj = 8'h01; step(); inj = 8'h00; step();
        n_vec++;
        if (flt1 !== 1'b0 || flg1 !== 8'h00 || tgt1 !== 8'h01 || st1 !== 2'd2 || st0 !== 2'd2) begin
            n_err++;
            $display("FAIL mask: got flt=%b flg=%h tgt=%h st1=%0d st0=%0d want 0 00 01 2 2",
                     flt1, flg1, tgt1, st1, st0);
        end
        en_mask = 8'hFF; step();
        n_vec++;
        if (flt1 !== 1'b1 || flg1 !== 8'h01 || cnt1 !== 8'd1) begin
            n_err++;
            $display("FAIL unmask: got flt=%b flg=%h cnt=%0d want 1 01 1", flt1, flg1, cnt1);
        end
    endtask

    task automatic test_saturate();
        go_idle(); do_load(8'h00); do_arm();
        inj = 8'hFF; step(); inj = 8'h00; step();
        n_vec++;
        if (cnt2 !== 2'd3 || flg2 !== 8'hFF || cnt1 !== 8'd8) begin
            n_err++;
            $display("FAIL count_sat: got cnt2=%0d flg2=%h cnt1=%0d want 3 ff 8", cnt2, flg2, cnt1);
        end
        go_idle(); do_load(8'h00); do_arm();
        for (int i = 0; i < 20; i++) step();
        inj = 8'h01; step(); inj = 8'h00; step();
        n_vec++;
        if (ft2 !== 4'd15 || ft1 !== 16'd21) begin
            n_err++; $display("FAIL timer_sat: got ft2=%0d ft1=%0d want 15 21", ft2, ft1);
        end
        inj = 8'hFE; step(); inj = 8'h00; step();
        n_vec++;
        if (cnt2 !== 2'd3 || cnt1 !== 8'd8 || idx1 !== 3'd0) begin
            n_err++;
            $display("FAIL count_nowrap: got cnt2=%0d cnt1=%0d idx1=%0d want 3 8 0", cnt2, cnt1, idx1);
        end
    endtask

    task automatic test_back_to_back();
        go_idle();
        load = 1'b1; arm = 1'b1; step(); load = 1'b0; arm = 1'b0;
        n_vec++;
        if (st0 !== 2'd1 || st1 !== 2'd1) begin
            n_err++; $display("FAIL load_wins: got st0=%0d st1=%0d want 1 1", st0, st1);
        end
        step();
        n_vec++;
        if (st0 !== 2'd0) begin n_err++; $display("FAIL load_to_idle: got %0d want 0", st0); end
        do_load(8'h00); do_arm();
        inj = 8'h01; step(); inj = 8'h00; disarm = 1'b1; step(); disarm = 1'b0;
        n_vec++;
        if (flt1 !== 1'b1 || flg1 !== 8'h01 || st1 !== 2'd0 || st0 !== 2'd0 || flg0 !== 8'h01) begin
            n_err++;
            $display("FAIL disarm_fault: got flt=%b flg1=%h st1=%0d st0=%0d flg0=%h want 1 01 0 0 01",
                     flt1, flg1, st1, st0, flg0);
        end
        step();
        n_vec++;
        if (flg1 !== 8'h01 || cnt1 !== 8'd1) begin
            n_err++; $display("FAIL persist: got flg=%h cnt=%0d want 01 1", flg1, cnt1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            load    = ($urandom_range(0, 11) == 0);
            arm     = ($urandom_range(0, 5) == 0);
            disarm  = ($urandom_range(0, 19) == 0);
            pattern = 8'($urandom);
            en_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            inj     = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            if ($urandom_range(0, 15) == 0) inj = 8'($urandom);
            step();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (o_st[k] !== m_st[k] || o_tgt[k] !== m_tgt[k] || o_flg[k] !== m_flg[k] ||
                    o_cnt[k] !== m_cnt[k] || o_idx[k] !== m_idx[k] || o_ft[k] !== m_ft[k] ||
                    o_flt[k] !== m_flt[k]) begin
                    n_err++;
                    $display("FAIL random[%0d] cyc %0d: got st=%0d tgt=%h flg=%h cnt=%0d idx=%0d ft=%0d flt=%0d want st=%0d tgt=%h flg=%h cnt=%0d idx=%0d ft=%0d flt=%0d",
                             k, i, o_st[k], o_tgt[k], o_flg[k], o_cnt[k], o_idx[k], o_ft[k], o_flt[k],
                             m_st[k], m_tgt[k], m_flg[k], m_cnt[k], m_idx[k], m_ft[k], m_flt[k]);
                end
            end
        end
        rst = 1'b0; load = 1'b0; arm = 1'b0; disarm = 1'b0; inj = 8'h00;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; arm = 1'b0; disarm = 1'b0;
        pattern = 8'h00; en_mask = 8'hFF; inj = 8'h00;
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_tgt[k] = 0; m_gold[k] = 0; m_flg[k] = 0;
            m_cnt[k] = 0; m_idx[k] = 0; m_ft[k] = 0; m_tmr[k] = 0; m_flt[k] = 0;
        end
        test_reset();
        test_detect_stop();
        test_reset_mid();
        test_accumulate();
        test_mask();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
